aes_decrypt_ctrl: RTL and testbench



---
 rtl/aes_decrypt_ctrl_pkg.sv | 76 +++++++
 rtl/aes_last_round.sv | 31 +++
 rtl/aes_decrypt_ctrl.sv | 101 ++++++++++
 tb/tb_aes_decrypt_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_decrypt_ctrl_pkg.sv
// Shared AES-128 decryption definitions: sizes, FSM encoding and
// the GF(2^8) helpers used by the inverse round datapath.
package aes_decrypt_ctrl_pkg;

    localparam int NR_AES128 = 10;
    localparam int BLK_W     = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        LAST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
            gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
            gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
            gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
            gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
        };
    endfunction

    function automatic logic [BLK_W-1:0] inv_mix_columns(
        input logic [BLK_W-1:0] s
    );
        logic [BLK_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            r[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
        return r;
    endfunction

endpackage

// File: rtl/aes_last_round.sv
// Inverse round without InvMixColumns:
// InvShiftRows, InvSubBytes, then AddRoundKey.
module aes_last_round
    import aes_decrypt_ctrl_pkg::*;
(
    input  logic [BLK_W-1:0] blk,
    input  logic [BLK_W-1:0] key,
    output logic [BLK_W-1:0] res
);

    logic [BLK_W-1:0] shifted;
    logic [BLK_W-1:0] subbed;

    // Byte (r,c) sits at index 4c+r; row r rotates right by r columns.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                shifted[127-8*(4*c+r) -: 8] =
                    blk[127-8*(4*((c-r+4)%4)+r) -: 8];
    end

    always_comb begin
        subbed = '0;
        for (int i = 0; i < 16; i++)
            subbed[127-8*i -: 8] = inv_sbox(shifted[127-8*i -: 8]);
    end

    assign res = subbed ^ key;

endmodule

// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES-128 decryption controller: one inverse round per
// clock, round keys fetched from an external store via rk_idx.
module aes_decrypt_ctrl
    import aes_decrypt_ctrl_pkg::*;
#(
    parameter int NR     = NR_AES128,
    parameter int KIDX_W = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BLK_W-1:0]  in_data,
    output logic [KIDX_W-1:0] rk_idx,
    input  logic [BLK_W-1:0]  rk_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BLK_W-1:0]  out_data,
    output logic              busy,
    output logic [KIDX_W-1:0] round
);

    state_t             state;
    state_t             state_nxt;
    logic [KIDX_W-1:0]  round_nxt;
    logic [BLK_W-1:0]   blk;
    logic [BLK_W-1:0]   blk_nxt;
    logic [BLK_W-1:0]   data_nxt;
    logic               valid_nxt;
    logic [BLK_W-1:0]   lr_res;
    logic [BLK_W-1:0]   round_res;

    // One shared datapath; the full round adds InvMixColumns on top.
    aes_last_round u_last_round (
        .blk (blk),
        .key (rk_data),
        .res (lr_res)
    );

    assign round_res = inv_mix_columns(lr_res);

    always_comb begin
        state_nxt = state;
        round_nxt = round;
        blk_nxt   = blk;
        data_nxt  = out_data;
        valid_nxt = out_valid;
        in_ready  = 1'b0;
        busy      = 1'b0;
        rk_idx    = KIDX_W'(NR);
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    blk_nxt   = in_data ^ rk_data;
                    round_nxt = KIDX_W'(NR - 1);
                    state_nxt = (NR == 1) ? LAST : ROUND;
                end
            end
            ROUND: begin
                busy      = 1'b1;
                rk_idx    = round;
                blk_nxt   = round_res;
                round_nxt = round - KIDX_W'(1);
                if (round == KIDX_W'(1))
                    state_nxt = LAST;
            end
            LAST: begin
                busy      = 1'b1;
                rk_idx    = '0;
                data_nxt  = lr_res;
                valid_nxt = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            round     <= '0;
            blk       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            round     <= round_nxt;
            blk       <= blk_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Bench for aes_decrypt_ctrl: FIPS-197 vectors plus random blocks
// against a byte-array inverse-cipher model.
module tb_aes_decrypt_ctrl;

    localparam int NR     = 10;
    localparam int KIDX_W = 4;
    localparam int NRAND  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [127:0]      in_data = '0;
    logic [KIDX_W-1:0] rk_idx;
    logic [127:0]      rk_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [127:0]      out_data;
    logic              busy;
    logic [KIDX_W-1:0] round;

    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];
    logic [127:0] mk [0:NR];
    logic [127:0] ks [0:NR];
    int           n_cmp = 0;
    int           n_err = 0;

    aes_decrypt_ctrl #(.NR(NR), .KIDX_W(KIDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round     (round)
    );

    always #5 clk = ~clk;

    always_comb begin
        rk_data = '0;
        if (int'(rk_idx) <= NR) rk_data = ks[int'(rk_idx)];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Forward S-box by brute-force inversion; inverse table by lookup.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                ^ rotl8(inv, 4) ^ 8'h63;
            sbox[a]  = s;
            isbox[s] = 8'(a);
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]],
                     sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++)
            mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic set_keys(input logic [127:0] key);
        expand_key(key);
        for (int r = 0; r <= NR; r++) ks[r] = mk[r];
    endtask

    function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   a [4];
        logic [7:0]   tmp;
        logic [7:0]   coef [4];
        logic [127:0] res;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int i = 0; i < 16; i++)
            s[i] = ct[127-8*i -: 8] ^ mk[NR][127-8*i -: 8];
        for (int rnd = NR - 1; rnd >= 0; rnd--) begin
            for (int r = 1; r < 4; r++)
                for (int k = 0; k < r; k++) begin
                    tmp     = s[r+12];
                    s[r+12] = s[r+8];
                    s[r+8]  = s[r+4];
                    s[r+4]  = s[r];
                    s[r]    = tmp;
                end
            for (int i = 0; i < 16; i++)
                s[i] = isbox[s[i]] ^ mk[rnd][127-8*i -: 8];
            if (rnd > 0)
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
                    for (int r = 0; r < 4; r++) begin
                        s[4*c+r] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            s[4*c+r] ^= gmul(coef[(j-r+4)%4], a[j]);
                    end
                end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_round"}, round, 0);
        check({tag, "_rk_idx"}, rk_idx, NR);
    endtask

    task automatic start_block(input logic [127:0] ct,
                               input logic [127:0] key);
        set_keys(key);
        in_data  = ct;
        in_valid = 1'b1;
        check("acc_in_ready", in_ready, 1);
        check("acc_rk_idx", rk_idx, NR);
        step();
        in_valid = 1'b0;
    endtask

    // Walks rounds, checks the result, stalls, then hands off.
    task automatic finish_block(input logic [127:0] exp, input int stall,
                                input bit chain, input logic [127:0] nct,
                                input logic [127:0] nkey);
        for (int k = NR - 1; k >= 0; k--) begin
            check("rk_idx", rk_idx, k);
            check("round", round, k);
            check("busy", busy, 1);
            check("run_in_ready", in_ready, 0);
            check("early_out_valid", out_valid, 0);
            in_valid  = 1'($urandom_range(1));
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'($urandom_range(1));
            step();
        end
        in_valid = 1'b0;
        check("out_valid", out_valid, 1);
        check("out_data", out_data, exp);
        check("done_busy", busy, 0);
        check("done_in_ready", in_ready, 0);
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom_range(1));
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            step();
            check("hold_out_data", out_data, exp);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        if (chain) begin
            set_keys(nkey);
            in_data  = nct;
            in_valid = 1'b1;
        end
        step();
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_busy", busy, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic [127:0] r_ct  [NRAND+1];
    logic [127:0] r_key [NRAND+1];
    logic [127:0] r_exp [NRAND+1];
    bit           r_chain;

    initial begin
        build_sbox();
        set_keys(C1_KEY);
        #3;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 50; i++) begin
            out_ready = 1'($urandom_range(1));
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            step();
            check("idle_in_ready", in_ready, 1);
            check("idle_busy", busy, 0);
            check("idle_rk_idx", rk_idx, NR);
            check("idle_out_valid", out_valid, 0);
        end
        out_ready = 1'b0;

        start_block(C1_CT, C1_KEY);
        finish_block(C1_PT, 0, 1'b0, '0, '0);

        start_block(C1_CT, C1_KEY);
        finish_block(C1_PT, 20, 1'b1, B_CT, B_KEY);
        start_block(B_CT, B_KEY);
        finish_block(B_PT, 0, 1'b0, '0, '0);

        start_block(C1_CT, C1_KEY);
        repeat (4) step();
        check("mid_round", round, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        start_block(B_CT, B_KEY);
        finish_block(B_PT, 1, 1'b0, '0, '0);

        for (int b = 0; b <= NRAND; b++) begin
            r_ct[b]  = {$urandom, $urandom, $urandom, $urandom};
            r_key[b] = {$urandom, $urandom, $urandom, $urandom};
            expand_key(r_key[b]);
            r_exp[b] = model_decrypt(r_ct[b]);
        end
        for (int b = 0; b < NRAND; b++) begin
            r_chain = (b < NRAND - 1) && ($urandom_range(1) == 1);
            start_block(r_ct[b], r_key[b]);
            finish_block(r_exp[b], int'($urandom_range(4)), r_chain,
                         r_ct[b+1], r_key[b+1]);
            if (!r_chain) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
